alu16_seq: RTL and testbench

//  Upstream sequencer for the 8-bit ALU: executes 16-bit ops (ADD HL,rr; INC rr; DEC rr; ADD SP,e8)
//  as two byte passes (low, then high with carry chained through ALU flag C). Sits between the

---
 rtl/alu16_seq.sv | 212 +++++++++++++++++++++
 tb/tb_alu16_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu16_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu16_seq
// Purpose  : Sequencer that runs 16-bit ops (ADD HL,rr / INC rr / DEC rr /
//            ADD SP,e8) on the 8-bit ALU as two byte passes. The low byte
//            goes first. The carry from the low pass is chained into the
//            high pass through the ALU C flag.
// Ports    : clk, rst (async, active-high)
//            start, op[1:0], opa[15:0], opb[15:0], flags_in[3:0] : request
//            busy, done, result[15:0], flags_out[3:0]           : status
//            alu_a, alu_b, alu_op, alu_flags_in                  : to ALU
//            alu_result, alu_flags_out                           : from ALU
// Config   : ALU16_SP_EN - when defined, op 2'b11 performs ADD SP,e8.
//            When undefined, op 2'b11 is a timed no-op. It returns
//            result=opa and flags_out=flags_in.
// Revision : 1.0 - initial release
// ============================================================================
module alu16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [3:0]  flags_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  flags_out,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_op,
  output logic [3:0]  alu_flags_in,
  input  logic [7:0]  alu_result,
  input  logic [3:0]  alu_flags_out
);

  // ALU op encodings
  localparam logic [4:0] c_ALU_ADD = 5'b00000;
  localparam logic [4:0] c_ALU_ADC = 5'b00001;
  localparam logic [4:0] c_ALU_SUB = 5'b00010;
  localparam logic [4:0] c_ALU_SBC = 5'b00011;

  // Sequencer op encodings
  localparam logic [1:0] c_OP_ADD16 = 2'b00;
  localparam logic [1:0] c_OP_INC16 = 2'b01;
  localparam logic [1:0] c_OP_DEC16 = 2'b10;
  localparam logic [1:0] c_OP_ADDSP = 2'b11;

  // FSM states
  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_LO   = 2'd1;
  localparam logic [1:0] c_S_HI   = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [1:0]  r_op;
  logic [15:0] r_opa;
  logic [15:0] r_opb;
  logic [3:0]  r_flags;
  logic [7:0]  r_res_lo;
  logic        r_c_lo;
  logic        r_done;
  logic [15:0] r_result;
  logic [3:0]  r_flags_out;
  logic        w_alu_active;
  logic [15:0] w_result_hi;
  logic [3:0]  w_flags_hi;
`ifdef ALU16_SP_EN
  logic        r_h_lo;
`endif

  // The ALU's Z and N outputs are never consumed. The 16-bit Z flag comes
  // from the latched F register, never from the ALU.
  logic w_unused;
  assign w_unused = &{1'b0, alu_flags_out[3:2]};

  // Without the SP feature, op 11 leaves the ALU parked as in IDLE.
`ifdef ALU16_SP_EN
  assign w_alu_active = 1'b1;
`else
  assign w_alu_active = (r_op != c_OP_ADDSP);
`endif

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (start) w_state_nxt = c_S_LO;
      c_S_LO:   w_state_nxt = c_S_HI;
      c_S_HI:   w_state_nxt = c_S_IDLE;
      default:  w_state_nxt = c_S_IDLE;
    endcase
  end

  // ------------------------------------------------------- output / ALU
  always_comb begin
    busy         = (r_state == c_S_LO) || (r_state == c_S_HI);
    alu_op       = c_ALU_ADD;
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_flags_in = 4'h0;
    if (w_alu_active) begin
      case (r_state)
        c_S_LO: begin
          alu_b = r_opa[7:0];
          case (r_op)
            c_OP_ADD16: alu_a = r_opb[7:0];
            c_OP_INC16: alu_a = 8'h01;
            c_OP_DEC16: begin
              alu_op = c_ALU_SUB;
              alu_a  = 8'h01;
            end
            default:    alu_a = r_opb[7:0];  // e8 added unsigned in the low pass
          endcase
        end
        c_S_HI: begin
          alu_flags_in = {3'b000, r_c_lo};
          alu_b        = r_opa[15:8];
          alu_op       = c_ALU_ADC;
          case (r_op)
            c_OP_ADD16: alu_a = r_opb[15:8];
            c_OP_INC16: alu_a = 8'h00;
            c_OP_DEC16: begin
              alu_op = c_ALU_SBC;
              alu_a  = 8'h00;
            end
            default:    alu_a = {8{r_opb[7]}};  // sign-extend e8
          endcase
        end
        default: ;
      endcase
    end
  end

  // Result and flags produced at the end of the high pass.
  always_comb begin
    w_result_hi = {alu_result, r_res_lo};
    w_flags_hi  = r_flags;
    case (r_op)
      c_OP_ADD16: w_flags_hi = {r_flags[3], 1'b0, alu_flags_out[1], alu_flags_out[0]};
      c_OP_INC16: w_flags_hi = r_flags;
      c_OP_DEC16: w_flags_hi = r_flags;
      default: begin
`ifdef ALU16_SP_EN
        // ADD SP,e8 reports the unsigned carries out of the low byte.
        w_flags_hi = {2'b00, r_h_lo, r_c_lo};
`else
        w_result_hi = r_opa;
        w_flags_hi  = r_flags;
`endif
      end
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= 2'b00;
      r_opa       <= 16'h0000;
      r_opb       <= 16'h0000;
      r_flags     <= 4'h0;
      r_res_lo    <= 8'h00;
      r_c_lo      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= 16'h0000;
      r_flags_out <= 4'h0;
`ifdef ALU16_SP_EN
      r_h_lo      <= 1'b0;
`endif
    end else begin
      r_done <= (r_state == c_S_HI);
      case (r_state)
        c_S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_opa   <= opa;
            r_opb   <= opb;
            r_flags <= flags_in;
          end
        end
        c_S_LO: begin
          r_res_lo <= alu_result;
          r_c_lo   <= alu_flags_out[0];
`ifdef ALU16_SP_EN
          r_h_lo   <= alu_flags_out[1];
`endif
        end
        c_S_HI: begin
          r_result    <= w_result_hi;
          r_flags_out <= w_flags_hi;
        end
        default: ;
      endcase
    end
  end

  assign done      = r_done;
  assign result    = r_result;
  assign flags_out = r_flags_out;

endmodule
`default_nettype wire

// File: tb/tb_alu16_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu16_seq
// Purpose  : Self-checking bench for alu16_seq. It provides a behavioural
//            8-bit ALU and a 16-bit arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [3:0]  flags_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  flags_out;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [4:0]  alu_op;
  logic [3:0]  alu_flags_in;
  logic [7:0]  alu_result;
  logic [3:0]  alu_flags_out;

  int n_checks = 0;
  int n_fail   = 0;

  alu16_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .opa          (opa),
    .opb          (opb),
    .flags_in     (flags_in),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .flags_out    (flags_out),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_flags_in (alu_flags_in),
    .alu_result   (alu_result),
    .alu_flags_out(alu_flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-bit ALU: result = b +/- a (+/- carry), flags {Z,N,H,C}.
  // For subtraction, C and H mean borrow.
  always_comb begin
    int b_i, a_i, c_i, s_i, h_i;
    b_i = int'(alu_b);
    a_i = int'(alu_a);
    c_i = alu_op[0] ? int'(alu_flags_in[0]) : 0;
    alu_result    = 8'h00;
    alu_flags_out = 4'h0;
    if (alu_op == 5'b00000 || alu_op == 5'b00001) begin
      s_i = b_i + a_i + c_i;
      h_i = (b_i % 16) + (a_i % 16) + c_i;
      alu_result    = s_i[7:0];
      alu_flags_out = {(s_i % 256) == 0, 1'b0, h_i > 15, s_i > 255};
    end else if (alu_op == 5'b00010 || alu_op == 5'b00011) begin
      s_i = b_i - a_i - c_i;
      h_i = (b_i % 16) - (a_i % 16) - c_i;
      alu_result    = s_i[7:0];
      alu_flags_out = {s_i[7:0] == 8'h00, 1'b1, h_i < 0, s_i < 0};
    end
  end

  // Reference model: returns {flags, result} from whole-word arithmetic.
  function automatic logic [19:0] ref_model(input logic [1:0] o, input logic [15:0] a,
                                            input logic [15:0] b, input logic [3:0] f);
    int s;
    logic [15:0] r;
    logic [3:0]  fo;
    r  = a;
    fo = f;
    case (o)
      2'b00: begin
        s  = int'(a) + int'(b);
        r  = s[15:0];
        fo = {f[3], 1'b0, (int'(a) % 4096) + (int'(b) % 4096) > 4095, s > 65535};
      end
      2'b01: r = a + 16'd1;
      2'b10: r = a - 16'd1;
      default: begin
`ifdef ALU16_SP_EN
        s  = int'(a) + int'($signed(b[7:0]));
        r  = s[15:0];
        fo = {2'b00, (int'(a) % 16) + (int'(b) % 16) > 15,
                     (int'(a) % 256) + int'(b[7:0]) > 255};
`else
        r  = a;
        fo = f;
`endif
      end
    endcase
    return {fo, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE (caller is 1 time unit after an edge). Inputs are
  // scrambled right after acceptance to show they are latched.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] f);
    logic [19:0] e;
    e = ref_model(o, a, b, f);
    op = o; opa = a; opb = b; flags_in = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); opa = 16'($urandom);
    opb = 16'($urandom); flags_in = 4'($urandom);
    chk({tag, " busy@N+1"}, busy, 1);
    chk({tag, " done@N+1"}, done, 0);
    @(posedge clk); #1;
    chk({tag, " busy@N+2"}, busy, 1);
    chk({tag, " done@N+2"}, done, 0);
    @(posedge clk); #1;
    chk({tag, " busy@N+3"}, busy, 0);
    chk({tag, " done@N+3"}, done, 1);
    chk({tag, " result"}, result, e[15:0]);
    chk({tag, " flags"}, flags_out, e[19:16]);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " result hold"}, result, e[15:0]);
  endtask

  initial begin
    logic [19:0] exp_q [3];
    rst = 1'b1; start = 1'b0; op = 2'b00; opa = 16'h0; opb = 16'h0; flags_in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 16'h0000);
    chk("reset flags", flags_out, 4'h0);
    chk("idle alu_op", alu_op, 5'b00000);
    chk("idle alu_ab", {alu_a, alu_b}, 16'h0000);
    chk("idle alu_fin", alu_flags_in, 4'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("add16 carry12", 2'b00, 16'h0FFF, 16'h0001, 4'b1000);
    chk("add16 carry12 lit", {flags_out, result}, {4'b1010, 16'h1000});
    do_op("add16 wrap", 2'b00, 16'hFFFF, 16'h0001, 4'b0000);
    chk("add16 wrap lit", {flags_out, result}, {4'b0011, 16'h0000});
    do_op("inc16 wrap", 2'b01, 16'hFFFF, 16'h1234, 4'b1011);
    chk("inc16 wrap lit", {flags_out, result}, {4'b1011, 16'h0000});
    do_op("dec16 wrap", 2'b10, 16'h0000, 16'h0000, 4'b0101);
    chk("dec16 wrap lit", {flags_out, result}, {4'b0101, 16'hFFFF});
`ifdef ALU16_SP_EN
    do_op("addsp pos", 2'b11, 16'h00FF, 16'h0001, 4'b1100);
    chk("addsp pos lit", {flags_out, result}, {4'b0011, 16'h0100});
    do_op("addsp neg", 2'b11, 16'h0000, 16'h00FF, 4'b1111);
    chk("addsp neg lit", {flags_out, result}, {4'b0000, 16'hFFFF});
`else
    do_op("addsp off", 2'b11, 16'h00FF, 16'h0001, 4'b1100);
    chk("addsp off lit", {flags_out, result}, {4'b1100, 16'h00FF});
`endif

    // Random ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      do_op("random", 2'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
    end

    // start held high every cycle: one op per 3 cycles, others ignored.
    for (int c = 0; c < 9; c++) begin
      op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom); flags_in = 4'($urandom);
      if (c % 3 == 0) exp_q[c / 3] = ref_model(op, opa, opb, flags_in);
      start = 1'b1;
      @(posedge clk); #1;
      chk("held busy", busy, (c % 3 != 2));
      chk("held done", done, (c % 3 == 2));
      if (c % 3 == 2) chk("held result", {flags_out, result}, exp_q[c / 3]);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("held drained", {busy, done}, 2'b00);

    // Reset during the high pass.
    op = 2'b00; opa = 16'h1234; opb = 16'h1111; flags_in = 4'h8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre-rst busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 16'h0000);
    chk("rst flags", flags_out, 4'h0);
    chk("rst alu_op", alu_op, 5'b00000);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post-rst no done", done, 0);
    end
    do_op("after rst", 2'b00, 16'h1234, 16'h1111, 4'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
